hazard_ctrl: RTL

//  Pipeline hazard and stall controller for the 5-stage RV32I core. Consumes register addresses from the
//  ID and EX, MEM and WB segment registers, plus branch/jump and D-cache miss status. Drives bubble/flush
//  to every segment register, including bubbleE/flushE of the ID/EX regs, and the EX-stage forwarding selects.

---
 rtl/hazard_pkg.sv | 7 +
 rtl/hazard_ctrl_fwd_sel_gen.sv | 16 +
 rtl/hazard_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: FSM state and forwarding-select encodings shared by hazard_ctrl and fwd_sel_gen
package hazard_pkg;
  typedef enum logic {RUN = 1'b0, MISS = 1'b1} state_e;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
endpackage

// File: rtl/hazard_ctrl_fwd_sel_gen.sv
// fwd_sel_gen: per-operand EX forwarding select; MEM beats WB, x0 never forwarded
module fwd_sel_gen
  import hazard_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] rd_mem_i,
  input  logic       wen_mem_i,
  input  logic [4:0] rd_wb_i,
  input  logic       wen_wb_i,
  output logic [1:0] sel_o
);
  logic mem_hit, wb_hit;
  assign mem_hit = wen_mem_i && rd_mem_i != 5'd0 && rd_mem_i == src_i;
  assign wb_hit  = wen_wb_i && rd_wb_i != 5'd0 && rd_wb_i == src_i;
  assign sel_o   = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_REG);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I 5-stage hazard/stall/forwarding controller.
// Define HAZARD_PERF_EN to enable saturating stall/flush/load-use counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       reg1_src_ID,
  input  logic [4:0]       reg2_src_ID,
  input  logic [4:0]       reg1_src_EX,
  input  logic [4:0]       reg2_src_EX,
  input  logic [4:0]       reg_dest_EX,
  input  logic [4:0]       reg_dest_MEM,
  input  logic [4:0]       reg_dest_WB,
  input  logic             load_EX,
  input  logic             reg_write_en_MEM,
  input  logic             reg_write_en_WB,
  input  logic             br_taken_EX,
  input  logic             jalr_EX,
  input  logic             jal_ID,
  input  logic             dcache_miss,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lduse_cnt
);
  state_e state_q, state_d;
  logic miss, redirect, lduse, jal;
  logic [1:0] fwd1, fwd2;
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && dcache_miss) state_d = MISS;
    if (state_q == MISS && !dcache_miss) state_d = RUN;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? RUN : state_d;
  end
  // Miss is honoured in either state and releases the cycle it drops, masking lower rules meanwhile
  assign miss     = !rst && dcache_miss;
  assign redirect = !rst && !dcache_miss && (br_taken_EX || jalr_EX);
  assign lduse    = !rst && !dcache_miss && !(br_taken_EX || jalr_EX) && load_EX &&
                    reg_dest_EX != 5'd0 &&
                    (reg_dest_EX == reg1_src_ID || reg_dest_EX == reg2_src_ID);
  assign jal      = !rst && !dcache_miss && !(br_taken_EX || jalr_EX) && !lduse && jal_ID;
  assign bubbleF  = miss || lduse;
  assign bubbleD  = miss || lduse;
  assign bubbleE  = miss;
  assign bubbleM  = miss;
  assign bubbleW  = 1'b0;
  assign flushF   = rst;
  assign flushD   = rst || redirect || jal;
  assign flushE   = rst || redirect || lduse;
  assign flushM   = rst;
  assign flushW   = rst || miss;
  fwd_sel_gen u_fwd1 (
    .src_i(reg1_src_EX), .rd_mem_i(reg_dest_MEM), .wen_mem_i(reg_write_en_MEM),
    .rd_wb_i(reg_dest_WB), .wen_wb_i(reg_write_en_WB), .sel_o(fwd1)
  );
  fwd_sel_gen u_fwd2 (
    .src_i(reg2_src_EX), .rd_mem_i(reg_dest_MEM), .wen_mem_i(reg_write_en_MEM),
    .rd_wb_i(reg_dest_WB), .wen_wb_i(reg_write_en_WB), .sel_o(fwd2)
  );
  assign fwd1_sel = rst ? FWD_REG : fwd1;
  assign fwd2_sel = rst ? FWD_REG : fwd2;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d, lduse_q, lduse_d;
  always_comb begin
    stall_d = (bubbleF && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (redirect && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
    lduse_d = (lduse && !(&lduse_q)) ? lduse_q + CNT_W'(1) : lduse_q;
  end
  always_ff @(posedge clk) begin
    stall_q <= rst ? '0 : stall_d;
    flush_q <= rst ? '0 : flush_d;
    lduse_q <= rst ? '0 : lduse_d;
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign lduse_cnt = lduse_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign lduse_cnt = '0;
`endif
endmodule
